// File: rtl/core_pkg.sv
// core_pkg: opcodes, datapath select encodings and sequencer states shared by the multicycle core.
package core_pkg;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;
   localparam logic [1:0] SRC_A_PC     = 2'b00;
   localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
   localparam logic [1:0] SRC_A_RS1    = 2'b10;
   localparam logic [1:0] SRC_B_RS2  = 2'b00;
   localparam logic [1:0] SRC_B_FOUR = 2'b01;
   localparam logic [1:0] SRC_B_IMM  = 2'b10;
   typedef enum logic [3:0] {
      FETCH, DECODE, EXEC_R, WB_R, MEM_ADDR, MEM_RD, WB_MEM, MEM_WR, BRANCH, ILLEGAL, BUSERR
   } mc_state_t;
   function automatic logic is_wait(input mc_state_t s);
      return s == FETCH || s == MEM_RD || s == MEM_WR;
   endfunction
   function automatic mc_state_t dispatch(input logic [6:0] op);
      return op == OP_RTYPE ? EXEC_R :
             (op == OP_LOAD || op == OP_STORE) ? MEM_ADDR :
             op == OP_BRANCH ? BRANCH : ILLEGAL;
   endfunction
endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: control/status bundle between the sequencer and the shared datapath.
interface multicycle_control_if #(parameter int CNT_W = 32);
   logic [6:0]       opcode;
   logic             zero;
   logic             mem_ready;
   logic             mem_read;
   logic             mem_write;
   logic             iord;
   logic             ir_write;
   logic             pc_write;
   logic             pc_src;
   logic             reg_write;
   logic             mem_to_reg;
   logic [1:0]       alu_src_a;
   logic [1:0]       alu_src_b;
   logic [1:0]       ALUOp;
   logic             illegal;
   logic             bus_err;
   logic             retired;
   logic [CNT_W-1:0] retired_count;
   modport master (
      input  opcode, zero, mem_ready,
      output mem_read, mem_write, iord, ir_write, pc_write, pc_src, reg_write, mem_to_reg,
             alu_src_a, alu_src_b, ALUOp, illegal, bus_err, retired, retired_count
   );
   modport slave (
      output opcode, zero, mem_ready,
      input  mem_read, mem_write, iord, ir_write, pc_write, pc_src, reg_write, mem_to_reg,
             alu_src_a, alu_src_b, ALUOp, illegal, bus_err, retired, retired_count
   );
endinterface

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts stalled memory cycles and flags the last one allowed before giving up.
module mem_wait_timer #(parameter int TIMEOUT = 16) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic ready,
   output logic expired
);
   logic [7:0] count;
   always_ff @(posedge clk)
      if (reset || start) count <= 8'd0;
      else if (!ready) count <= count + 8'd1;
   assign expired = !ready && count == 8'(TIMEOUT - 1);
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore sequencer stepping the shared datapath through RV32 R/LW/SW/BEQ.
module multicycle_control
   import core_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input logic clk,
   input logic reset,
   multicycle_control_if.master bus
);
   mc_state_t        state, nxt;
   logic [6:0]       opcode_q;
   logic [CNT_W-1:0] count;
   logic             expired;
   // Timer restarts whenever we are outside a wait state or the access completes.
   mem_wait_timer #(.TIMEOUT(MEM_TIMEOUT)) timer (
      .clk(clk),
      .reset(reset),
      .start(!is_wait(state) || bus.mem_ready),
      .ready(bus.mem_ready),
      .expired(expired)
   );
   always_comb begin
      nxt = FETCH;
      case (state)
         FETCH:    nxt = bus.mem_ready ? DECODE : expired ? BUSERR : FETCH;
         DECODE:   nxt = dispatch(bus.opcode);
         EXEC_R:   nxt = WB_R;
         MEM_ADDR: nxt = opcode_q == OP_LOAD ? MEM_RD : MEM_WR;
         MEM_RD:   nxt = bus.mem_ready ? WB_MEM : expired ? BUSERR : MEM_RD;
         MEM_WR:   nxt = bus.mem_ready ? FETCH : expired ? BUSERR : MEM_WR;
         default:  nxt = FETCH;
      endcase
   end
   always_comb begin
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.iord       = 1'b0;
      bus.ir_write   = 1'b0;
      bus.pc_write   = 1'b0;
      bus.pc_src     = 1'b0;
      bus.reg_write  = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.alu_src_a  = SRC_A_PC;
      bus.alu_src_b  = SRC_B_RS2;
      bus.ALUOp      = ALU_ADD;
      bus.illegal    = 1'b0;
      bus.bus_err    = 1'b0;
      bus.retired    = 1'b0;
      if (!reset)
         case (state)
            FETCH: begin
               bus.mem_read  = 1'b1;
               bus.alu_src_b = SRC_B_FOUR;
               bus.ir_write  = bus.mem_ready;
               bus.pc_write  = bus.mem_ready;
            end
            DECODE: begin
               bus.alu_src_a = SRC_A_OLD_PC;
               bus.alu_src_b = SRC_B_IMM;
            end
            EXEC_R: begin
               bus.alu_src_a = SRC_A_RS1;
               bus.ALUOp     = ALU_FUNCT;
            end
            WB_R: begin
               bus.reg_write = 1'b1;
               bus.retired   = 1'b1;
            end
            MEM_ADDR: begin
               bus.alu_src_a = SRC_A_RS1;
               bus.alu_src_b = SRC_B_IMM;
            end
            MEM_RD: begin
               bus.mem_read = 1'b1;
               bus.iord     = 1'b1;
            end
            WB_MEM: begin
               bus.reg_write  = 1'b1;
               bus.mem_to_reg = 1'b1;
               bus.retired    = 1'b1;
            end
            MEM_WR: begin
               bus.mem_write = 1'b1;
               bus.iord      = 1'b1;
               bus.retired   = bus.mem_ready;
            end
            BRANCH: begin
               bus.alu_src_a = SRC_A_RS1;
               bus.ALUOp     = ALU_SUB;
               bus.pc_src    = 1'b1;
               bus.pc_write  = bus.zero;
               bus.retired   = 1'b1;
            end
            ILLEGAL: bus.illegal = 1'b1;
            BUSERR:  bus.bus_err = 1'b1;
            default: ;
         endcase
   end
   always_ff @(posedge clk)
      if (reset) begin
         state    <= FETCH;
         opcode_q <= 7'd0;
         count    <= '0;
      end else begin
         state <= nxt;
         if (state == DECODE) opcode_q <= bus.opcode;
         if (bus.retired) count <= count + CNT_W'(1);
      end
   assign bus.retired_count = count;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: checks the sequencer cycle by cycle against a phase-list model of each instruction.
module tb_multicycle_control;
   import core_pkg::*;
   localparam int T = 16;
   typedef enum {PH_FETCH, PH_DEC, PH_EXR, PH_WBR, PH_ADDR, PH_RD, PH_WBM, PH_WR, PH_BR, PH_ILL, PH_BUS} ph_t;
   typedef struct {
      logic        rdy;
      logic        z;
      logic [6:0]  op;
      logic [16:0] exp;
      logic [31:0] cnt;
   } cyc_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   cyc_t pq[$];
   cyc_t c;
   logic [31:0] m_cnt = 0;
   int n_cmp = 0;
   int n_fail = 0;
   multicycle_control_if #(.CNT_W(32)) bus();
   multicycle_control #(.MEM_TIMEOUT(T), .CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   function automatic logic [16:0] obs();
      return {bus.mem_read, bus.mem_write, bus.iord, bus.ir_write, bus.pc_write, bus.pc_src,
              bus.reg_write, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b, bus.ALUOp,
              bus.illegal, bus.bus_err, bus.retired};
   endfunction
   // Output pattern each phase must show, straight from the control table; r is mem_ready or zero.
   function automatic logic [16:0] vec(input ph_t ph, input logic r);
      case (ph)
         PH_FETCH: return {1'b1, 1'b0, 1'b0, r, r, 3'b000, 2'b00, 2'b01, 2'b00, 3'b000};
         PH_DEC:   return {8'b0, 2'b01, 2'b10, 2'b00, 3'b000};
         PH_EXR:   return {8'b0, 2'b10, 2'b00, 2'b10, 3'b000};
         PH_WBR:   return {6'b0, 1'b1, 1'b0, 6'b0, 3'b001};
         PH_ADDR:  return {8'b0, 2'b10, 2'b10, 2'b00, 3'b000};
         PH_RD:    return {1'b1, 1'b0, 1'b1, 5'b0, 6'b0, 3'b000};
         PH_WBM:   return {6'b0, 1'b1, 1'b1, 6'b0, 3'b001};
         PH_WR:    return {1'b0, 1'b1, 1'b1, 5'b0, 6'b0, 2'b00, r};
         PH_BR:    return {4'b0, r, 1'b1, 2'b00, 2'b10, 2'b00, 2'b01, 3'b001};
         PH_ILL:   return {14'b0, 3'b100};
         default:  return {14'b0, 3'b010};
      endcase
   endfunction
   function automatic logic rb();
      return 1'($urandom);
   endfunction
   function automatic logic [6:0] ro();
      return 7'($urandom);
   endfunction
   function automatic void push(input ph_t ph, input logic r, input logic rdy, input logic z, input logic [6:0] op);
      cyc_t k;
      k.exp = vec(ph, r);
      k.rdy = rdy;
      k.z   = z;
      k.op  = op;
      k.cnt = m_cnt;
      pq.push_back(k);
      if (k.exp[0]) m_cnt = m_cnt + 1;
   endfunction
   // A memory phase stalled w cycles: completes after w stalls, or gives up after T stalls.
   function automatic bit pw(input ph_t ph, input int w);
      int n = w >= T ? T : w;
      for (int i = 0; i < n; i++) push(ph, 1'b0, 1'b0, rb(), ro());
      if (w >= T) begin
         push(PH_BUS, 1'b0, rb(), rb(), ro());
         return 1'b0;
      end
      push(ph, 1'b1, 1'b1, rb(), ro());
      return 1'b1;
   endfunction
   function automatic void plan(input logic [6:0] op, input logic z, input int fw, input int mw);
      if (!pw(PH_FETCH, fw)) return;
      push(PH_DEC, 1'b0, rb(), rb(), op);
      if (op == OP_RTYPE) begin
         push(PH_EXR, 1'b0, rb(), rb(), ro());
         push(PH_WBR, 1'b0, rb(), rb(), ro());
      end else if (op == OP_LOAD) begin
         push(PH_ADDR, 1'b0, rb(), rb(), ro());
         if (pw(PH_RD, mw)) push(PH_WBM, 1'b0, rb(), rb(), ro());
      end else if (op == OP_STORE) begin
         push(PH_ADDR, 1'b0, rb(), rb(), ro());
         void'(pw(PH_WR, mw));
      end else if (op == OP_BRANCH) push(PH_BR, z, rb(), z, ro());
      else push(PH_ILL, 1'b0, rb(), rb(), ro());
   endfunction
   task automatic drive(input cyc_t k);
      bus.mem_ready = k.rdy;
      bus.zero      = k.z;
      bus.opcode    = k.op;
      #2;
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      m_cnt = 0;
      pq.delete();
   endtask
   task automatic test_reset();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.mem_ready = 1'b1;
         bus.zero      = rb();
         bus.opcode    = ro();
         #2;
         n_cmp++;
         if (obs() !== 17'd0) begin n_fail++; $display("FAIL reset_outputs: got %b want 0", obs()); end
         tick();
      end
      n_cmp++;
      if (bus.retired_count !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.retired_count); end
      reset = 1'b0;
      m_cnt = 0;
   endtask
   task automatic test_rtype();
      do_reset();
      plan(OP_RTYPE, 1'b0, 0, 0);
      plan(OP_RTYPE, 1'b0, 2, 0);
      while (pq.size() > 0) begin
         c = pq.pop_front();
         drive(c);
         n_cmp += 2;
         if (obs() !== c.exp) begin n_fail++; $display("FAIL rtype_out: got %b want %b", obs(), c.exp); end
         if (bus.retired_count !== c.cnt) begin n_fail++; $display("FAIL rtype_cnt: got %0d want %0d", bus.retired_count, c.cnt); end
         tick();
      end
      n_cmp++;
      if (bus.retired_count !== 32'd2) begin n_fail++; $display("FAIL rtype_final: got %0d want 2", bus.retired_count); end
   endtask
   task automatic test_lw_wait();
      do_reset();
      plan(OP_LOAD, 1'b0, 0, 3);
      plan(OP_LOAD, 1'b0, 0, T - 1);
      while (pq.size() > 0) begin
         c = pq.pop_front();
         drive(c);
         n_cmp += 2;
         if (obs() !== c.exp) begin n_fail++; $display("FAIL lw_out: got %b want %b", obs(), c.exp); end
         if (bus.retired_count !== c.cnt) begin n_fail++; $display("FAIL lw_cnt: got %0d want %0d", bus.retired_count, c.cnt); end
         tick();
      end
   endtask
   task automatic test_beq();
      do_reset();
      plan(OP_BRANCH, 1'b1, 0, 0);
      plan(OP_BRANCH, 1'b0, 0, 0);
      while (pq.size() > 0) begin
         c = pq.pop_front();
         drive(c);
         n_cmp += 2;
         if (obs() !== c.exp) begin n_fail++; $display("FAIL beq_out: got %b want %b", obs(), c.exp); end
         if (bus.retired_count !== c.cnt) begin n_fail++; $display("FAIL beq_cnt: got %0d want %0d", bus.retired_count, c.cnt); end
         tick();
      end
      n_cmp++;
      if (bus.retired_count !== 32'd2) begin n_fail++; $display("FAIL beq_final: got %0d want 2", bus.retired_count); end
   endtask
   task automatic test_illegal();
      do_reset();
      plan(7'b0010011, 1'b0, 0, 0);
      plan(OP_RTYPE, 1'b0, 0, 0);
      while (pq.size() > 0) begin
         c = pq.pop_front();
         drive(c);
         n_cmp += 2;
         if (obs() !== c.exp) begin n_fail++; $display("FAIL illegal_out: got %b want %b", obs(), c.exp); end
         if (bus.retired_count !== c.cnt) begin n_fail++; $display("FAIL illegal_cnt: got %0d want %0d", bus.retired_count, c.cnt); end
         tick();
      end
   endtask
   task automatic test_sw_timeout();
      do_reset();
      plan(OP_STORE, 1'b0, 0, 1000);
      plan(OP_STORE, 1'b0, T, 0);
      plan(OP_STORE, 1'b0, 1, 2);
      while (pq.size() > 0) begin
         c = pq.pop_front();
         drive(c);
         n_cmp += 2;
         if (obs() !== c.exp) begin n_fail++; $display("FAIL sw_out: got %b want %b", obs(), c.exp); end
         if (bus.retired_count !== c.cnt) begin n_fail++; $display("FAIL sw_cnt: got %0d want %0d", bus.retired_count, c.cnt); end
         tick();
      end
   endtask
   task automatic test_reset_mid();
      do_reset();
      plan(OP_RTYPE, 1'b0, 0, 0);
      plan(OP_LOAD, 1'b0, 0, 50);
      for (int i = 0; i < 9; i++) begin
         c = pq.pop_front();
         drive(c);
         n_cmp++;
         if (obs() !== c.exp) begin n_fail++; $display("FAIL midrst_pre: got %b want %b", obs(), c.exp); end
         tick();
      end
      pq.delete();
      reset = 1'b1;
      bus.mem_ready = 1'b0;
      #2;
      n_cmp++;
      if (obs() !== 17'd0) begin n_fail++; $display("FAIL midrst_out: got %b want 0", obs()); end
      tick();
      reset = 1'b0;
      m_cnt = 0;
      plan(OP_RTYPE, 1'b0, 0, 0);
      while (pq.size() > 0) begin
         c = pq.pop_front();
         drive(c);
         n_cmp += 2;
         if (obs() !== c.exp) begin n_fail++; $display("FAIL midrst_post: got %b want %b", obs(), c.exp); end
         if (bus.retired_count !== c.cnt) begin n_fail++; $display("FAIL midrst_cnt: got %0d want %0d", bus.retired_count, c.cnt); end
         tick();
      end
   endtask
   task automatic test_random();
      logic [6:0] op;
      do_reset();
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 4))
            0: op = OP_RTYPE;
            1: op = OP_LOAD;
            2: op = OP_STORE;
            3: op = OP_BRANCH;
            default: op = ro();
         endcase
         plan(op, rb(), $urandom_range(0, 7) == 0 ? $urandom_range(10, 20) : $urandom_range(0, 3),
              $urandom_range(0, 7) == 0 ? $urandom_range(10, 20) : $urandom_range(0, 3));
      end
      while (pq.size() > 0) begin
         c = pq.pop_front();
         drive(c);
         n_cmp += 2;
         if (obs() !== c.exp) begin n_fail++; $display("FAIL random_out: got %b want %b", obs(), c.exp); end
         if (bus.retired_count !== c.cnt) begin n_fail++; $display("FAIL random_cnt: got %0d want %0d", bus.retired_count, c.cnt); end
         tick();
      end
   endtask
   initial begin
      bus.mem_ready = 1'b0;
      bus.zero      = 1'b0;
      bus.opcode    = 7'd0;
      tick();
      test_reset();
      test_rtype();
      test_lw_wait();
      test_beq();
      test_illegal();
      test_sw_timeout();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the RV32 subset the core decodes: R-type, LW, SW and BEQ. It replaces single-cycle decode with a Moore FSM that steps the shared datapath through fetch, decode, execute, memory and writeback. The shared datapath is one ALU, one unified memory port, the IR/old-PC/ALUOut registers and the register file. It also handles memory wait states with a timeout, and counts retired instructions.

## Interface
- `MEM_TIMEOUT`, default 16: maximum cycles spent waiting for `mem_ready` in one memory state. Legal range is 2..255.
- `CNT_W`, default 32: width of `retired_count`.
- `clk` input 1: the single clock. All state changes on the rising edge.
- `reset` input 1: synchronous, active-high.
- `opcode` input 7: IR[6:0] from the datapath. Sampled only in DECODE.
- `zero` input 1: ALU zero flag. Used only in BRANCH.
- `mem_ready` input 1: memory completes the current access this cycle.
- `mem_read`, `mem_write` output 1 each: memory strobes.
- `iord` output 1: memory address select. 0 = PC, 1 = ALUOut.
- `ir_write` output 1: load IR and old-PC.
- `pc_write` output 1: load PC.
- `pc_src` output 1: PC source. 0 = ALU result, 1 = ALUOut.
- `reg_write` output 1: register file write enable.
- `mem_to_reg` output 1: writeback source. 0 = ALUOut, 1 = MDR.
- `alu_src_a` output 2: ALU A operand. 00 = PC, 01 = old-PC, 10 = rs1.
- `alu_src_b` output 2: ALU B operand. 00 = rs2, 01 = constant 4, 10 = immediate.
- `ALUOp` output 2: 00 = add, 01 = sub/compare, 10 = decode by funct.
- `illegal` output 1: one-cycle pulse for an unsupported opcode.
- `bus_err` output 1: one-cycle pulse when a memory access times out.
- `retired` output 1: one-cycle pulse when an instruction completes.
- `retired_count` output `CNT_W`: total instructions retired.

## Operation
- States: FETCH, DECODE, EXEC_R, WB_R, MEM_ADDR, MEM_RD, WB_MEM, MEM_WR, BRANCH, ILLEGAL, BUSERR.
- Every control output not listed for a state is 0.
- FETCH
  - Outputs: `mem_read`=1, `iord`=0, `alu_src_a`=00, `alu_src_b`=01, `ALUOp`=00.
  - `ir_write`, `pc_write` = `mem_ready` (PC ← PC+4 on completion).
  - Transition: DECODE on `mem_ready`.
- DECODE
  - Outputs: `alu_src_a`=01, `alu_src_b`=10, `ALUOp`=00 (ALUOut ← branch target).
  - Latches `opcode` into an internal `opcode_q`.
  - Transitions: 0110011 → EXEC_R; 0000011 or 0100011 → MEM_ADDR; 1100011 → BRANCH; any other value → ILLEGAL.
- EXEC_R
  - Outputs: `alu_src_a`=10, `alu_src_b`=00, `ALUOp`=10.
  - Transition: WB_R.
- WB_R
  - Outputs: `reg_write`=1, `mem_to_reg`=0, `retired`=1.
  - Transition: FETCH.
- MEM_ADDR
  - Outputs: `alu_src_a`=10, `alu_src_b`=10, `ALUOp`=00.
  - Transitions: MEM_RD if `opcode_q` = 0000011, otherwise MEM_WR.
- MEM_RD
  - Outputs: `mem_read`=1, `iord`=1.
  - Transition: WB_MEM on `mem_ready`.
- WB_MEM
  - Outputs: `reg_write`=1, `mem_to_reg`=1, `retired`=1.
  - Transition: FETCH.
- MEM_WR
  - Outputs: `mem_write`=1, `iord`=1, `retired` = `mem_ready`.
  - Transition: FETCH on `mem_ready`.
- BRANCH
  - Outputs: `alu_src_a`=10, `alu_src_b`=00, `ALUOp`=01, `pc_src`=1, `pc_write` = `zero`, `retired`=1.
  - Transition: FETCH.
- ILLEGAL
  - Outputs: `illegal`=1. No architectural write.
  - Transition: FETCH. The PC has already advanced, so the instruction is skipped. Not counted as retired.
- BUSERR
  - Outputs: `bus_err`=1.
  - Transition: FETCH. The access is abandoned with no register or PC write (for a fetch timeout, the PC is not advanced). Not counted as retired.
- Wait timer
  - Resets to 0 on entry to FETCH, MEM_RD and MEM_WR.
  - Increments on each cycle in those states with `mem_ready`=0.
  - When it reaches `MEM_TIMEOUT`-1 with `mem_ready` still 0, the next state is BUSERR.
  - If `mem_ready`=1 in that same cycle, completion wins.
- `retired_count` increments on every `retired` pulse and wraps modulo 2^`CNT_W`.

## Timing
- Reset
  - While `reset`=1, all control outputs and pulses are 0.
  - State register goes to FETCH; `retired_count`, `opcode_q` and the wait timer go to 0.
  - The first cycle after deassertion is FETCH.
  - Reset takes effect mid-instruction from any state. No partial write completes afterwards.
- All outputs are decoded combinationally from the state register, plus `mem_ready` and `zero` where listed.
- Latency with `mem_ready` held at 1:
  - R-type: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ: 3 cycles.
  - Illegal opcode: 3 cycles.
- Each cycle of `mem_ready`=0 in FETCH, MEM_RD or MEM_WR adds one cycle.
- `retired_count` shows the new value the cycle after the `retired` pulse.

## Structure
- Shared package `core_pkg` holds:
  - Opcode constants: `OP_RTYPE`, `OP_LOAD`, `OP_STORE`, `OP_BRANCH`.
  - `ALUOp` encodings.
  - `alu_src_a` and `alu_src_b` select encodings.
  - The `mc_state_t` state enum.
- The wait timer is one natural sub-module, `mem_wait_timer`, with inputs `clk`, `reset`, `start`, `ready` and output `expired`.
- The FSM and the retire counter stay in the top-level module.

## Test plan
- Reset → `mem_ready`=1, R-type opcode 0110011 → states FETCH, DECODE, EXEC_R, WB_R. `reg_write`=1 only in cycle 4. `retired_count`=1.
- LW with `mem_ready` low for 3 cycles in MEM_RD → 8-cycle instruction. `mem_read` and `iord` held at 1 for 4 cycles, then WB_MEM with `mem_to_reg`=1.
- BEQ twice, first with `zero`=1 then with `zero`=0 → `pc_write`=1 with `pc_src`=1 in cycle 3 of the first, `pc_write`=0 in the second. `retired_count`=2.
- Opcode 0010011 → `illegal` pulses in cycle 3. `reg_write` is never asserted. `retired_count` is unchanged. Next cycle is FETCH.
- SW with `mem_ready` held at 0 and `MEM_TIMEOUT`=16 → after 16 cycles in MEM_WR, a one-cycle `bus_err`, then FETCH. `retired` is never pulsed.
- `reset` asserted during MEM_RD wait → the next cycle has all outputs 0. After release, FETCH is entered with `retired_count`=0.
